seg_scan_driver: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It sits directly upstream of the per-digit hex-to-segment decoder and feeds it one nibble, one dot bit and one enable at a time. It drives the active-low digit anodes in step, and double-buffers display updates so new values take effect only at a frame boundary. It also provides anti-ghosting guard time, leading-zero blanking and per-digit blink.

---
 rtl/seg_scan_driver.sv | 192 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display, feeding a per-digit hex decoder.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   load_valid   producer offers a new display value
//   load_ready   block can accept a value (shadow buffer empty)
//   load_data    hex nibbles, digit i = bits [4i+3:4i]
//   load_dots    decimal-point bit per digit
//   blink_mask   1 = digit blinks (live, not buffered)
//   dig_dat      nibble to decoder
//   dig_dot      dot to decoder
//   dig_en       decoder enable, 0 = segments dark
//   an_n         active-low anode select, at most one bit low
//   frame_done   one-cycle pulse after the scan wraps to digit 0
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 64,
   parameter int LZ_BLANK     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_dots,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [3:0]              dig_dat,
   output logic                    dig_dot,
   output logic                    dig_en,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

   // scan position
   logic [DW-1:0] r_div_cnt;
   logic [IW-1:0] r_idx;

   // double buffer
   logic [4*NUM_DIGITS-1:0] r_sh_dat;
   logic [NUM_DIGITS-1:0]   r_sh_dot;
   logic [4*NUM_DIGITS-1:0] r_act_dat;
   logic [NUM_DIGITS-1:0]   r_act_dot;
   logic                    r_pending;

   // blink timing
   logic [FW-1:0] r_frm_cnt;
   logic          r_blink;

   // registered outputs
   logic [NUM_DIGITS-1:0] r_an_n;
   logic [3:0]            r_dig_dat;
   logic                  r_dig_dot;
   logic                  r_dig_en;
   logic                  r_frame_done;

   // combinational helpers
   logic                  w_slot_end;
   logic                  w_boundary;
   logic                  w_xfer;
   logic                  w_commit;
   logic                  w_guard;
   logic                  w_lz;
   logic                  w_blink_off;
   logic                  w_off;
   logic                  w_zero_run;
   logic [NUM_DIGITS-1:0] w_zero_from;
   logic [NUM_DIGITS-1:0] w_an_sel;
   logic [3:0]            w_nib [NUM_DIGITS];

   assign load_ready = ~rst & ~r_pending;

   assign w_slot_end = (r_div_cnt == DIV_LAST);
   assign w_boundary = w_slot_end & (r_idx == IDX_LAST);
   assign w_xfer     = load_valid & load_ready;
   // xfer needs pending=0 and commit needs pending=1, so a value
   // accepted on the boundary cycle waits for the next boundary
   assign w_commit   = w_boundary & r_pending;

   // w_zero_from[i]: every nibble from the top digit down to i is zero
   always_comb begin
      w_zero_run  = 1'b1;
      w_zero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_nib[i]       = r_act_dat[4*i +: 4];
         w_zero_run     = w_zero_run & (w_nib[i] == 4'h0);
         w_zero_from[i] = w_zero_run;
      end
   end

   always_comb begin
      w_guard     = (r_div_cnt < BLANK_END);
      w_lz        = (LZ_BLANK != 0) && (r_idx != '0) &&
                    w_zero_from[r_idx];
      w_blink_off = r_blink & blink_mask[r_idx];
      w_off       = w_guard | w_lz | w_blink_off;
      w_an_sel    = ~(NUM_DIGITS'(1) << r_idx);
   end

   // slot divider and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
      end else begin
         if (w_slot_end) begin
            r_div_cnt <= '0;
            if (r_idx == IDX_LAST) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + IW'(1);
            end
         end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
         end
      end
   end

   // shadow / active buffers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_dat  <= '0;
         r_sh_dot  <= '0;
         r_act_dat <= '0;
         r_act_dot <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_sh_dat  <= load_data;
            r_sh_dot  <= load_dots;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
         if (w_commit) begin
            r_act_dat <= r_sh_dat;
            r_act_dot <= r_sh_dot;
         end
      end
   end

   // blink phase toggles every BLINK_FRAMES frames
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frm_cnt <= '0;
         r_blink   <= 1'b0;
      end else if (w_boundary) begin
         if (r_frm_cnt == FRM_LAST) begin
            r_frm_cnt <= '0;
            r_blink   <= ~r_blink;
         end else begin
            r_frm_cnt <= r_frm_cnt + FW'(1);
         end
      end
   end

   // output stage, one cycle behind the scan position
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an_n       <= '1;
         r_dig_dat    <= 4'h0;
         r_dig_dot    <= 1'b0;
         r_dig_en     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_an_n       <= w_guard ? '1 : w_an_sel;
         r_dig_dat    <= w_nib[r_idx];
         r_dig_dot    <= ~w_off & r_act_dot[r_idx];
         r_dig_en     <= ~w_off;
         r_frame_done <= w_boundary;
      end
   end

   assign an_n       = r_an_n;
   assign dig_dat    = r_dig_dat;
   assign dig_dot    = r_dig_dot;
   assign dig_en     = r_dig_en;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: lockstep bench for seg_scan_driver against a
// cycle-count based reference model of the scan and buffering rules.
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int CD = 8;
   localparam int BC = 2;
   localparam int BF = 2;
   localparam int LZ = 1;
   localparam int FR = N * CD;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_valid = 1'b0;
   logic           load_ready;
   logic [4*N-1:0] load_data = '0;
   logic [N-1:0]   load_dots = '0;
   logic [N-1:0]   blink_mask = '0;
   logic [3:0]     dig_dat;
   logic           dig_dot;
   logic           dig_en;
   logic [N-1:0]   an_n;
   logic           frame_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .NUM_DIGITS  (N),
      .CLK_DIV     (CD),
      .BLANK_CYC   (BC),
      .BLINK_FRAMES(BF),
      .LZ_BLANK    (LZ)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .load_dots (load_dots),
      .blink_mask(blink_mask),
      .dig_dat   (dig_dat),
      .dig_dot   (dig_dot),
      .dig_en    (dig_en),
      .an_n      (an_n),
      .frame_done(frame_done)
   );

   // reference model state
   int             m_k;
   int             m_frames;
   bit             m_pend;
   logic [4*N-1:0] m_act_dat;
   logic [4*N-1:0] m_sh_dat;
   logic [N-1:0]   m_act_dot;
   logic [N-1:0]   m_sh_dot;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t",
                  tag, obs, exp, $time);
      end
   endtask

   // highest digit holding a non-zero nibble (0 when all are zero)
   function automatic int top_digit(input logic [4*N-1:0] d);
      int t;
      t = 0;
      for (int i = 0; i < N; i++)
         if (d[4*i +: 4] != 4'h0) t = i;
      return t;
   endfunction

   task automatic model_reset();
      m_k       = 0;
      m_frames  = 0;
      m_pend    = 1'b0;
      m_act_dat = '0;
      m_sh_dat  = '0;
      m_act_dot = '0;
      m_sh_dot  = '0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         check("rst_ready", load_ready, 0);
         @(posedge clk);
         #1;
         check("rst_an", an_n, {N{1'b1}});
         check("rst_en", dig_en, 0);
         check("rst_dat", dig_dat, 0);
         check("rst_dot", dig_dot, 0);
         check("rst_fd", frame_done, 0);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic step();
      int         div;
      int         idx;
      bit         guard;
      bit         ph;
      bit         blank;
      bit         bnd;
      bit         xfer;
      logic [N-1:0] e_an;
      logic [3:0] e_dat;
      logic       e_en;
      logic       e_dot;
      #1;
      div   = m_k % CD;
      idx   = (m_k / CD) % N;
      guard = (div < BC);
      ph    = ((m_frames / BF) % 2) == 1;
      blank = guard || (LZ != 0 && idx > top_digit(m_act_dat)) ||
              (ph && blink_mask[idx]);
      e_an  = guard ? {N{1'b1}} : ~(N'(1) << idx);
      e_dat = m_act_dat[4*idx +: 4];
      e_en  = !blank;
      e_dot = blank ? 1'b0 : m_act_dot[idx];
      bnd   = (m_k % FR) == FR - 1;
      check("ready", load_ready, {31'd0, !m_pend});
      xfer  = load_valid && !m_pend;
      @(posedge clk);
      if (bnd) begin
         m_frames++;
         if (m_pend) begin
            m_act_dat = m_sh_dat;
            m_act_dot = m_sh_dot;
            m_pend    = 1'b0;
         end
      end
      if (xfer) begin
         m_sh_dat = load_data;
         m_sh_dot = load_dots;
         m_pend   = 1'b1;
      end
      m_k++;
      #1;
      check("an_n", an_n, e_an);
      check("dig_en", dig_en, e_en);
      check("dig_dat", dig_dat, e_dat);
      check("dig_dot", dig_dot, e_dot);
      check("frame_done", frame_done, bnd);
   endtask

   task automatic drive_load(input logic [4*N-1:0] d,
                             input logic [N-1:0] p);
      load_valid = 1'b1;
      load_data  = d;
      load_dots  = p;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      do_reset(3);

      // idle scan
      repeat (40) step();

      // load mid-frame
      while (m_k % FR != 10) step();
      drive_load(16'h0A05, 4'b0010);
      repeat (70) step();

      // back-to-back loads, second one stalls
      load_valid = 1'b1;
      load_data  = 16'h1111;
      load_dots  = 4'b0001;
      step();
      load_data  = 16'h2222;
      load_dots  = 4'b1000;
      for (int i = 0; i < FR + 2 && m_pend; i++) step();
      step();
      load_valid = 1'b0;
      repeat (80) step();

      // blink on digit 0
      blink_mask = 4'b0001;
      drive_load(16'h1234, 4'b0000);
      repeat (6 * FR) step();
      blink_mask = 4'b0000;

      // transfer exactly on the boundary cycle
      for (int i = 0; i < 2 * FR && !((m_k % FR == FR - 1) && !m_pend); i++)
         step();
      drive_load(16'h5678, 4'b0101);
      repeat (2 * FR + 4) step();

      // reset mid-slot with a load pending
      repeat (3) step();
      drive_load(16'h9ABC, 4'b1111);
      repeat (3) step();
      do_reset(1);
      repeat (40) step();

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
         load_dots  = 4'($urandom);
         if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
         if ($urandom_range(0, 499) == 0)
            do_reset($urandom_range(1, 2));
         else
            step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
